crt_mode_ctl: RTL and testbench

Sequencer that configures the CRT pixel-clock divider's resolution mode (`med_res`) on host request without producing a torn or malformed frame. Sits between the host/register interface and the pixel-clock divider plus timing generator. It blanks video, waits for a frame boundary, switches `med_res`, holds the timing generator in reset for a settle time counted in 1 µs ticks, then unblanks on the next frame boundary.

---
 rtl/crt_pkg.sv | 30 +++
 rtl/crt_us_timer.sv | 45 ++++
 rtl/crt_mode_ctl.sv | 160 ++++++++++++++++
 tb/tb_crt_mode_ctl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/crt_pkg.sv
// Shared types and constants for the CRT resolution-mode sequencer.
package crt_pkg;

  // Width of the microsecond tick counter shared by all waiting states.
  localparam int CRT_US_CNT_W = 16;

  // Default settle and frame-boundary timeout, in 1 us ticks.
  localparam int CRT_SETTLE_US_DEF  = 64;
  localparam int CRT_TIMEOUT_US_DEF = 25000;

  // Sequencer states.
  typedef enum logic [2:0] {
    CRT_ST_IDLE    = 3'd0,
    CRT_ST_WAIT_VS = 3'd1,
    CRT_ST_SWITCH  = 3'd2,
    CRT_ST_SETTLE  = 3'd3,
    CRT_ST_UNBLANK = 3'd4
  } crt_mode_state_t;

  // States in which the microsecond counter advances on onemks.
  function automatic logic crt_state_timed(input crt_mode_state_t s);
    return (s == CRT_ST_WAIT_VS) || (s == CRT_ST_SETTLE) || (s == CRT_ST_UNBLANK);
  endfunction

  // States that may finish on a frame boundary pulse.
  function automatic logic crt_state_waits_vs(input crt_mode_state_t s);
    return (s == CRT_ST_WAIT_VS) || (s == CRT_ST_UNBLANK);
  endfunction

endpackage

// File: rtl/crt_us_timer.sv
// Microsecond tick counter with a terminal flag after exactly n ticks.
module crt_us_timer
  import crt_pkg::*;
(
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clr,
  input  logic                    en,
  input  logic                    tick,
  input  logic [CRT_US_CNT_W-1:0] n,
  output logic                    expire,
  output logic [CRT_US_CNT_W-1:0] count
);

  localparam logic [CRT_US_CNT_W-1:0] CNT_ONE = 1;

  logic [CRT_US_CNT_W-1:0] count_q;
  logic [CRT_US_CNT_W-1:0] count_d;
  logic [CRT_US_CNT_W-1:0] n_last;

  // The n-th tick is the one seen while the count still reads n-1; a tick in
  // the clearing cycle still counts because clr takes effect at the edge.
  always_comb begin
    n_last  = n - CNT_ONE;
    expire  = en && tick && (count_q == n_last);
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && tick) begin
      count_d = count_q + CNT_ONE;
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/crt_mode_ctl.sv
// Sequencer that changes the pixel-clock divider mode only while video is
// blanked and the timing generator is held in reset, aligned to frame ends.
module crt_mode_ctl
  import crt_pkg::*;
#(
  parameter int   SETTLE_US     = CRT_SETTLE_US_DEF,
  parameter int   TIMEOUT_US    = CRT_TIMEOUT_US_DEF,
  parameter logic RESET_MED_RES = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic onemks,
  input  logic vsync_end,
  input  logic req_valid,
  input  logic req_med_res,
  output logic req_ready,
  output logic med_res,
  output logic blank,
  output logic tg_reset,
  output logic done,
  output logic timeout
);

  localparam logic [CRT_US_CNT_W-1:0] SETTLE_N  = CRT_US_CNT_W'(SETTLE_US);
  localparam logic [CRT_US_CNT_W-1:0] TIMEOUT_N = CRT_US_CNT_W'(TIMEOUT_US);

  crt_mode_state_t state_q;
  crt_mode_state_t state_d;

  logic target_q;
  logic target_d;

  logic req_ready_q, req_ready_d;
  logic med_res_q,   med_res_d;
  logic blank_q,     blank_d;
  logic tg_reset_q,  tg_reset_d;
  logic done_q,      done_d;
  logic timeout_q,   timeout_d;

  logic                    accept;
  logic                    timer_clr;
  logic                    timer_en;
  logic [CRT_US_CNT_W-1:0] timer_n;
  logic                    timer_expire;
  logic [CRT_US_CNT_W-1:0] timer_count;

  assign accept = req_valid && req_ready_q;

  // One counter serves every waiting state; it restarts on any state change
  // and uses the settle length only while settling.
  always_comb begin
    timer_clr = (state_d != state_q);
    timer_en  = crt_state_timed(state_q);
    timer_n   = (state_q == CRT_ST_SETTLE) ? SETTLE_N : TIMEOUT_N;
  end

  crt_us_timer u_timer (
    .clk    (clk),
    .reset  (reset),
    .clr    (timer_clr),
    .en     (timer_en),
    .tick   (onemks),
    .n      (timer_n),
    .expire (timer_expire),
    .count  (timer_count)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= CRT_ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a request for the mode already in force never leaves IDLE.
  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    case (state_q)
      CRT_ST_IDLE: begin
        if (accept) begin
          target_d = req_med_res;
          if (req_med_res != med_res_q) begin
            state_d = CRT_ST_WAIT_VS;
          end
        end
      end
      CRT_ST_WAIT_VS: begin
        if (vsync_end || timer_expire) begin
          state_d = CRT_ST_SWITCH;
        end
      end
      CRT_ST_SWITCH: begin
        state_d = CRT_ST_SETTLE;
      end
      CRT_ST_SETTLE: begin
        if (timer_expire) begin
          state_d = CRT_ST_UNBLANK;
        end
      end
      CRT_ST_UNBLANK: begin
        if (vsync_end || timer_expire) begin
          state_d = CRT_ST_IDLE;
        end
      end
      default: begin
        state_d = CRT_ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop. The mode
  // is written at the end of SWITCH, which is the same edge that raises
  // tg_reset on entry to SETTLE, so the divider never changes with the
  // timing generator running.
  always_comb begin
    req_ready_d = (state_q == CRT_ST_IDLE) && (state_d == CRT_ST_IDLE);
    blank_d     = (state_d != CRT_ST_IDLE);
    tg_reset_d  = (state_d == CRT_ST_SETTLE);
    med_res_d   = (state_q == CRT_ST_SWITCH) ? target_q : med_res_q;
    done_d      = ((state_q == CRT_ST_IDLE) && accept && (state_d == CRT_ST_IDLE)) ||
                  ((state_q == CRT_ST_UNBLANK) && (state_d == CRT_ST_IDLE));
    // A frame boundary in the same cycle as the last tick is not a timeout.
    timeout_d   = crt_state_waits_vs(state_q) && timer_expire && !vsync_end;
  end

  // Output registers; an in-flight request is simply dropped by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_q <= 1'b1;
      med_res_q   <= RESET_MED_RES;
      blank_q     <= 1'b0;
      tg_reset_q  <= 1'b0;
      done_q      <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      req_ready_q <= req_ready_d;
      med_res_q   <= med_res_d;
      blank_q     <= blank_d;
      tg_reset_q  <= tg_reset_d;
      done_q      <= done_d;
      timeout_q   <= timeout_d;
    end
  end

  // Requested mode, held from acceptance until it is applied in SWITCH.
  always_ff @(posedge clk) begin
    target_q <= target_d;
  end

  assign req_ready = req_ready_q;
  assign med_res   = med_res_q;
  assign blank     = blank_q;
  assign tg_reset  = tg_reset_q;
  assign done      = done_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_crt_mode_ctl.sv
// Bench for crt_mode_ctl: directed stimulus with a pulse scoreboard for done/timeout.
module tb_crt_mode_ctl;

  logic clk = 1'b0;
  logic reset;
  logic onemks;
  logic vsync_end;
  logic req_valid;
  logic req_med_res;
  logic req_ready;
  logic med_res;
  logic blank;
  logic tg_reset;
  logic done;
  logic timeout;

  typedef struct {
    int   cyc;
    logic d;
    logic t;
    logic m;
    logic b;
  } exp_t;

  exp_t exp_q[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_pass   = 0;

  crt_mode_ctl #(
    .SETTLE_US     (4),
    .TIMEOUT_US    (8),
    .RESET_MED_RES (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .onemks      (onemks),
    .vsync_end   (vsync_end),
    .req_valid   (req_valid),
    .req_med_res (req_med_res),
    .req_ready   (req_ready),
    .med_res     (med_res),
    .blank       (blank),
    .tg_reset    (tg_reset),
    .done        (done),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
  endtask

  // Drive tick/vsync for one cycle, return 1 time unit after the edge.
  task automatic step(input logic t, input logic v);
    onemks    = t;
    vsync_end = v;
    @(posedge clk);
    #1;
    onemks    = 1'b0;
    vsync_end = 1'b0;
  endtask

  task automatic ticks(input int k);
    repeat (k) step(1'b1, 1'b0);
  endtask

  // Expect a done/timeout pulse in the cycle after the current one.
  task automatic push_exp(input logic d, input logic t, input logic m, input logic b);
    exp_t e;
    e.cyc = cyc + 1;
    e.d = d;
    e.t = t;
    e.m = m;
    e.b = b;
    exp_q.push_back(e);
  endtask

  // Scoreboard: match each done/timeout pulse against the queued expectation.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc && !(done || timeout)) begin
      e = exp_q.pop_front();
      check_eq("pulse_missing_cyc", cyc, e.cyc);
    end
    if (done === 1'b1 || timeout === 1'b1) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_done", int'(done), 0);
        check_eq("unexpected_timeout", int'(timeout), 0);
      end else begin
        e = exp_q.pop_front();
        check_eq("pulse_cyc", cyc, e.cyc);
        check_eq("pulse_done", int'(done), int'(e.d));
        check_eq("pulse_timeout", int'(timeout), int'(e.t));
        check_eq("pulse_med_res", int'(med_res), int'(e.m));
        check_eq("pulse_blank", int'(blank), int'(e.b));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    reset       = 1'b1;
    onemks      = 1'b0;
    vsync_end   = 1'b0;
    req_valid   = 1'b0;
    req_med_res = 1'b0;
    repeat (3) step(1'b0, 1'b0);
    check_eq("rst_ready", int'(req_ready), 1);
    check_eq("rst_med_res", int'(med_res), 0);
    check_eq("rst_blank", int'(blank), 0);
    check_eq("rst_tg_reset", int'(tg_reset), 0);
    check_eq("rst_done", int'(done), 0);
    check_eq("rst_timeout", int'(timeout), 0);
    reset = 1'b0;
    step(1'b0, 1'b0);

    // Frame boundary while idle is ignored.
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("idle_vs_blank", int'(blank), 0);
    check_eq("idle_vs_ready", int'(req_ready), 1);

    // Normal switch 0 -> 1 on a frame boundary.
    req_valid = 1'b1; req_med_res = 1'b1;
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    check_eq("t1_blank_t1", int'(blank), 1);
    check_eq("t1_ready_busy", int'(req_ready), 0);
    check_eq("t1_tg_wait", int'(tg_reset), 0);
    ticks(5);
    step(1'b0, 1'b0);
    check_eq("t1_med_wait", int'(med_res), 0);
    step(1'b0, 1'b1);
    check_eq("t1_med_switch", int'(med_res), 0);
    check_eq("t1_tg_switch", int'(tg_reset), 0);
    step(1'b1, 1'b0);
    check_eq("t1_med_settle", int'(med_res), 1);
    check_eq("t1_tg_settle", int'(tg_reset), 1);
    ticks(3);
    check_eq("t1_tg_hold", int'(tg_reset), 1);
    step(1'b1, 1'b0);
    check_eq("t1_tg_unblank", int'(tg_reset), 0);
    check_eq("t1_blank_unblank", int'(blank), 1);
    step(1'b0, 1'b0);
    push_exp(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_eq("t1_blank_done", int'(blank), 0);
    check_eq("t1_ready_done", int'(req_ready), 0);
    step(1'b0, 1'b0);
    check_eq("t1_ready_back", int'(req_ready), 1);

    // No-op request for the current mode.
    req_valid = 1'b1; req_med_res = 1'b1;
    push_exp(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    check_eq("t2_blank", int'(blank), 0);
    check_eq("t2_tg", int'(tg_reset), 0);
    check_eq("t2_ready", int'(req_ready), 1);
    check_eq("t2_med", int'(med_res), 1);
    step(1'b0, 1'b0);
    check_eq("t2_done_once", int'(done), 0);
    check_eq("t2_blank_after", int'(blank), 0);

    // Timeout in both waiting states.
    req_valid = 1'b1; req_med_res = 1'b0;
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    ticks(7);
    check_eq("t3_no_early_to", int'(timeout), 0);
    push_exp(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0);
    check_eq("t3_med_switch", int'(med_res), 1);
    step(1'b0, 1'b0);
    check_eq("t3_med_settle", int'(med_res), 0);
    check_eq("t3_tg_settle", int'(tg_reset), 1);
    ticks(4);
    check_eq("t3_tg_unblank", int'(tg_reset), 0);
    ticks(7);
    check_eq("t3_no_early_done", int'(done), 0);
    push_exp(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0);
    check_eq("t3_blank_done", int'(blank), 0);
    step(1'b0, 1'b0);
    check_eq("t3_ready_back", int'(req_ready), 1);

    // Frame boundary coincident with the expiring tick wins.
    req_valid = 1'b1; req_med_res = 1'b1;
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    ticks(7);
    step(1'b1, 1'b1);
    check_eq("t4_no_timeout", int'(timeout), 0);
    step(1'b0, 1'b0);
    check_eq("t4_med_settle", int'(med_res), 1);
    check_eq("t4_tg_settle", int'(tg_reset), 1);

    // Request held while busy, accepted once back in IDLE, reverts the mode.
    req_valid = 1'b1; req_med_res = 1'b0;
    step(1'b1, 1'b0);
    check_eq("t5_ready_settle", int'(req_ready), 0);
    ticks(2);
    check_eq("t5_ready_settle2", int'(req_ready), 0);
    step(1'b1, 1'b0);
    check_eq("t5_ready_unblank", int'(req_ready), 0);
    push_exp(1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b1);
    check_eq("t5_ready_done", int'(req_ready), 0);
    step(1'b0, 1'b0);
    check_eq("t5_ready_idle", int'(req_ready), 1);
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    check_eq("t5_blank_accept", int'(blank), 1);
    check_eq("t5_ready_accept", int'(req_ready), 0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("t5_med_revert", int'(med_res), 0);
    check_eq("t5_tg_revert", int'(tg_reset), 1);
    ticks(4);
    push_exp(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // Reset while settling drops the request.
    req_valid = 1'b1; req_med_res = 1'b1;
    step(1'b0, 1'b0);
    req_valid = 1'b0;
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check_eq("t6_med_settle", int'(med_res), 1);
    check_eq("t6_tg_settle", int'(tg_reset), 1);
    step(1'b1, 1'b0);
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
    check_eq("t6_med_rst", int'(med_res), 0);
    check_eq("t6_blank_rst", int'(blank), 0);
    check_eq("t6_tg_rst", int'(tg_reset), 0);
    check_eq("t6_ready_rst", int'(req_ready), 1);
    check_eq("t6_done_rst", int'(done), 0);
    step(1'b0, 1'b1);
    repeat (3) step(1'b0, 1'b0);
    check_eq("t6_blank_idle", int'(blank), 0);
    check_eq("t6_med_idle", int'(med_res), 0);

    check_eq("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
